// File: rtl/aes_key_schedule_engine_pkg.sv
// Shared AES key-schedule definitions: key-size encodings, mode lookups,
// GF(2^8) doubling and the forward S-box used by SubWord.
package aes_key_schedule_engine_pkg;

    typedef enum logic [1:0] {
        KEY_128     = 2'd0,
        KEY_192     = 2'd1,
        KEY_256     = 2'd2,
        KEY_ILLEGAL = 2'd3
    } key_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Element 0 is the leftmost byte, so SBOX[x] is the substitution of x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] ks);
        case (ks)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        case (ks)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] total_words(input logic [1:0] ks);
        logic [3:0] nr_p1;
        nr_p1 = nr_of(ks) + 4'd1;
        return {nr_p1, 2'b00};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_schedule_engine_key_word_gen.sv
// Combinational next schedule word for i >= Nk: w[i] = w[i-Nk] ^ t(w[i-1]).
module aes_key_schedule_engine_key_word_gen
    import aes_key_schedule_engine_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_back,
    input  logic [2:0]  imod,
    input  logic [3:0]  nk,
    input  logic [7:0]  rcon,
    output logic [31:0] w_out
);

    logic [31:0] t;

    always_comb begin
        t = w_prev;
        if (imod == 3'd0) begin
            t = sub_word(rot_word(w_prev)) ^ {rcon, 24'h000000};
        end else if (nk == 4'd8 && imod == 3'd4) begin
            // Extra substitution only in the 256-bit schedule.
            t = sub_word(w_prev);
        end
        w_out = w_back ^ t;
    end

endmodule

// File: rtl/aes_key_schedule_engine.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per cycle, packed
// into 128-bit round keys and streamed out over a valid/ready handshake.
module aes_key_schedule_engine
    import aes_key_schedule_engine_pkg::*;
#(
    parameter int BYTE    = 8,
    parameter int DWORD   = 32,
    parameter int LENGTH  = 128,
    parameter int KEY_MAX = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         key_Size,
    input  logic [KEY_MAX-1:0] key_In,
    output logic               rk_Valid,
    input  logic               rk_Ready,
    output logic [LENGTH-1:0]  round_Key_Out,
    output logic [3:0]         rk_Index,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int KEY_WORDS = KEY_MAX / DWORD;

    state_e                              state_q, state_d;
    logic [0:KEY_WORDS-1][DWORD-1:0]     key_q, key_d;
    logic [KEY_WORDS-1:0][DWORD-1:0]     win_q, win_d;
    logic [0:2][DWORD-1:0]               col_q, col_d;
    logic [5:0]                          i_q, i_d;
    logic [2:0]                          imod_q, imod_d;
    logic [BYTE-1:0]                     rcon_q, rcon_d;
    logic [3:0]                          nk_q, nk_d;
    logic [5:0]                          total_q, total_d;
    logic                                rk_valid_q, rk_valid_d;
    logic [LENGTH-1:0]                   rk_key_q, rk_key_d;
    logic [3:0]                          rk_index_q, rk_index_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;

    logic [2:0]       nk_m1;
    logic             from_key;
    logic             transfer;
    logic             stall;
    logic             produce;
    logic [DWORD-1:0] gen_word;
    logic [DWORD-1:0] new_word;

    assign nk_m1    = 3'(nk_q - 4'd1);
    assign from_key = (i_q < {2'b00, nk_q});
    assign transfer = rk_valid_q && rk_Ready;
    // The collector is full exactly when the next word would complete a round key.
    assign stall    = rk_valid_q && !rk_Ready && (i_q[1:0] == 2'd3);
    assign produce  = (state_q == ST_RUN) && !stall;
    assign new_word = from_key ? key_q[i_q[2:0]] : gen_word;

    aes_key_schedule_engine_key_word_gen u_key_word_gen (
        .w_prev (win_q[0]),
        .w_back (win_q[nk_m1]),
        .imod   (imod_q),
        .nk     (nk_q),
        .rcon   (rcon_q),
        .w_out  (gen_word)
    );

    // win_q[k] holds w[i-1-k]; the shift happens only when a word is produced.
    generate
        for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_window
            if (gi == 0) begin : g_head
                assign win_d[gi] = produce ? new_word : win_q[gi];
            end else begin : g_tail
                assign win_d[gi] = produce ? win_q[gi-1] : win_q[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        col_d      = col_q;
        i_d        = i_q;
        imod_d     = imod_q;
        rcon_d     = rcon_q;
        nk_d       = nk_q;
        total_d    = total_q;
        rk_valid_d = rk_valid_q && !rk_Ready;
        rk_key_d   = rk_key_q;
        rk_index_d = rk_index_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (key_Size == KEY_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        key_d   = key_In;
                        nk_d    = nk_of(key_Size);
                        total_d = total_words(key_Size);
                        i_d     = '0;
                        imod_d  = '0;
                        rcon_d  = RCON_INIT;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (produce) begin
                    i_d    = i_q + 6'd1;
                    imod_d = (imod_q == nk_m1) ? 3'd0 : imod_q + 3'd1;
                    if (!from_key && imod_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    case (i_q[1:0])
                        2'd0: col_d[0] = new_word;
                        2'd1: col_d[1] = new_word;
                        2'd2: col_d[2] = new_word;
                        default: begin
                            rk_key_d   = {col_q[0], col_q[1], col_q[2], new_word};
                            rk_index_d = i_q[5:2];
                            rk_valid_d = 1'b1;
                        end
                    endcase
                    if (i_q == total_q - 6'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (transfer) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            win_q      <= '0;
            col_q      <= '0;
            i_q        <= '0;
            imod_q     <= '0;
            rcon_q     <= '0;
            nk_q       <= '0;
            total_q    <= '0;
            rk_valid_q <= 1'b0;
            rk_key_q   <= '0;
            rk_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            win_q      <= win_d;
            col_q      <= col_d;
            i_q        <= i_d;
            imod_q     <= imod_d;
            rcon_q     <= rcon_d;
            nk_q       <= nk_d;
            total_q    <= total_d;
            rk_valid_q <= rk_valid_d;
            rk_key_q   <= rk_key_d;
            rk_index_q <= rk_index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rk_Valid      = rk_valid_q;
    assign round_Key_Out = rk_key_q;
    assign rk_Index      = rk_index_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Scoreboard bench for the AES key-schedule engine using FIPS-197 vectors.
module tb_aes_key_schedule_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_Size = 2'd0;
    logic [255:0] key_In = '0;
    logic         rk_Ready = 1'b1;
    logic         rk_Valid;
    logic [127:0] round_Key_Out;
    logic [3:0]   rk_Index;
    logic         busy;
    logic         done;
    logic         err;

    aes_key_schedule_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key_Size      (key_Size),
        .key_In        (key_In),
        .rk_Valid      (rk_Valid),
        .rk_Ready      (rk_Ready),
        .round_Key_Out (round_Key_Out),
        .rk_Index      (rk_Index),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic         chk;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    bit           rand_ready = 1'b0;
    logic [3:0]   exp_last = 4'd0;
    bit           pending_done = 1'b0;
    bit           stall_prev = 1'b0;
    logic [131:0] prev_out = '0;
    exp_t         e;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] aes128_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void get_exp(input logic [1:0] ks, input int r, output logic chk, output logic [127:0] k);
        chk = 1'b1;
        k   = '0;
        case (ks)
            2'd0: k = aes128_rk[r];
            2'd1: case (r)
                0:       k = 128'h8e73b0f7da0e6452c810f32b809079e5;
                1:       k = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
                12:      k = 128'he98ba06f448c773c8ecc720401002202;
                default: chk = 1'b0;
            endcase
            default: case (r)
                0:       k = 128'h603deb1015ca71be2b73aef0857d7781;
                1:       k = 128'h1f352c073b6108d72d9810a30914dff4;
                2:       k = 128'h9ba354118e6925afa51a8b5f2067fcde;
                3:       k = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
                14:      k = 128'hfe4890d1e6188d0b046df344706c631e;
                default: chk = 1'b0;
            endcase
        endcase
    endfunction

    // Push the expected stream, launch the key and optionally check rk0 latency.
    task automatic run_key(input logic [1:0] ks, input logic [255:0] key, input int nr, input bit timing);
        logic         c;
        logic [127:0] k;
        for (int r = 0; r <= nr; r++) begin
            get_exp(ks, r, c, k);
            exp_q.push_back('{idx: 4'(r), chk: c, key: k});
        end
        exp_last = 4'(nr);
        @(posedge clk); #1;
        start = 1'b1; key_Size = ks; key_In = key;
        @(posedge clk); #1;
        start = 1'b0; key_In = '0;
        if (timing) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("rk0_not_before_edge4", {131'b0, rk_Valid}, 132'd0);
            @(negedge clk);
            check("rk0_valid_after_edge4", {131'b0, rk_Valid}, 132'd1);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_clears_in_time", {131'b0, busy}, 132'd0);
        check("all_keys_delivered", 132'(exp_q.size()), 132'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            rk_Ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks done timing and stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending_done = 1'b0;
                stall_prev   = 1'b0;
            end else begin
                if (pending_done) begin
                    check("done_busy_after_last", {130'b0, done, busy}, 132'b10);
                    pending_done = 1'b0;
                end else begin
                    check("no_spurious_done", {131'b0, done}, 132'd0);
                end
                if (stall_prev) begin
                    check("stall_hold", {rk_Valid, 127'b0, rk_Index} ^ {1'b0, 127'b0, prev_out[131:128]},
                          {1'b1, 131'b0});
                    check("stall_key_hold", {4'b0, round_Key_Out}, {4'b0, prev_out[127:0]});
                end
                if (rk_Valid && rk_Ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_key", {128'b0, rk_Index}, 132'hfff);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer rk_Index=%0d key=%h", rk_Index, round_Key_Out);
                        check("rk_index", {128'b0, rk_Index}, {128'b0, e.idx});
                        if (e.chk) check("round_key", {4'b0, round_Key_Out}, {4'b0, e.key});
                        if (e.idx == exp_last) pending_done = 1'b1;
                    end
                end
                stall_prev = rk_Valid && !rk_Ready;
                prev_out   = {rk_Index, round_Key_Out};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {rk_Valid, round_Key_Out, rk_Index, busy, done, err}, 132'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start = 1'b1; key_Size = 2'd3; key_In = KEY128;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", {129'b0, err, busy, rk_Valid}, 132'b100);
        @(negedge clk);
        check("err_single_cycle", {130'b0, err, busy}, 132'd0);

        run_key(2'd0, KEY128, 10, 1'b1);
        wait_idle(2000);
        run_key(2'd1, KEY192, 12, 1'b1);
        wait_idle(2000);
        run_key(2'd2, KEY256, 14, 1'b1);
        wait_idle(2000);

        rand_ready = 1'b1;
        run_key(2'd0, KEY128, 10, 1'b0);
        repeat (10) @(posedge clk); #1;
        start = 1'b1; key_Size = 2'd2; key_In = KEY256;
        @(posedge clk); #1;
        start = 1'b0; key_In = '0;
        check("start_ignored_busy", {131'b0, busy}, 132'd1);
        wait_idle(3000);
        rand_ready = 1'b0;

        run_key(2'd2, KEY256, 14, 1'b0);
        repeat (20) @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {rk_Valid, round_Key_Out, rk_Index, busy, done, err}, 132'd0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        run_key(2'd0, KEY128, 10, 1'b1);
        wait_idle(2000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_engine.md
Name: aes_key_schedule_engine

Overview:
- Iterative, multi-mode AES key-schedule generator; parametrised successor of the single-step AES-128 next-round-key block.
- Accepts a 128/192/256-bit cipher key and produces one 32-bit schedule word per cycle.
- Packs the words into 128-bit round keys and streams them to the round datapath over a valid/ready handshake.
- Sits between key load and the cipher round pipeline; replaces per-round combinational expansion with a shared sequential engine.

Parameters:
- BYTE, 8, byte width
- DWORD, 32, schedule word width
- LENGTH, 128, round-key / block width
- KEY_MAX, 256, widest supported cipher key

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request; sampled in IDLE only
- key_Size  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal
- key_In  in  KEY_MAX  cipher key, left-aligned; w0 = key_In[255:224]; unused LSBs ignored
- rk_Valid  out  1  round_Key_Out holds a valid round key
- rk_Ready  in  1  consumer accepts the round key
- round_Key_Out  out  LENGTH  round key; w(4r) in [127:96], w(4r+3) in [31:0]
- rk_Index  out  4  round number r of round_Key_Out
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the final round key is accepted
- err  out  1  one-cycle pulse when start is sampled with key_Size == 3

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all outputs are 0; state IDLE; window, collector, word counter i and Rcon register are cleared.
- Mode constants:
  - Nk = 4 / 6 / 8 words.
  - Nr = 10 / 12 / 14 rounds.
  - Total words = 4*(Nr+1) = 44 / 52 / 60.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start with legal key_Size: latch key_In and Nk/Nr; set i = 0 and Rcon = 0x01; busy = 1; go to RUN.
  - IDLE, start with key_Size == 3: pulse err; stay in IDLE.
  - start is ignored outside IDLE.
- RUN: produce one word w[i] per non-stalled cycle.
  - i < Nk: w[i] is taken from the latched key.
  - Otherwise w[i] = w[i-Nk] ^ t, where t is derived from w[i-1]:
    - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}; then Rcon <= xtime(Rcon), with xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
    - Nk == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - Sliding window holds the last Nk words: 8 x DWORD shift register, read at depth Nk.
- Collector: 3-word buffer.
  - On the edge that produces word 4r+3, round_Key_Out <= {c0, c1, c2, w}; rk_Index <= r; rk_Valid <= 1.
  - Timing with rk_Ready held high: start is captured at edge 0, word i is produced at edge i+1, and round key r becomes valid after edge 4r+4.
  - Word production is one per cycle with no bubbles.
- Stall: when rk_Valid && !rk_Ready && the collector holds 3 words, no word is produced; i and Rcon hold.
- Handshake:
  - The transfer is rk_Valid && rk_Ready.
  - rk_Valid drops after a transfer unless a new key loads on the same edge; load wins.
  - round_Key_Out and rk_Index are stable while rk_Valid && !rk_Ready.
- After the last word (i = total-1) is produced: go to DRAIN.
  - In DRAIN, on the final transfer: pulse done for 1 cycle with busy = 0 on the same cycle; go to IDLE.
- rk_Index range: 0..Nr, increasing, never skipped.
- Reset mid-operation: immediate abort; no done; outputs return to reset values.

Decomposition:
- Shared package (aes_pkg):
  - Key-size encodings.
  - NK/NR lookup functions.
  - Total-word count.
  - xtime function.
  - S-box table (shared with the existing SubWord block).
- One sub-module, key_word_gen: combinational w[i] from w[i-1], w[i-Nk], i mod Nk, Nk and Rcon. It reuses the existing RotWord/SubWord blocks.
- The FSM, window, collector and handshake stay in the top module.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_Ready = 1:
  - rk0 equals the key, valid 4 cycles after start.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done 1 cycle after the rk10 transfer; 11 transfers total.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rk12 = e98ba06f448c773c8ecc720401002202.
  - rk_Index runs 0..12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk14 = fe4890d1e6188d0b046df344706c631e.
  - rk1 = 1f352c073b6108d72d9810a30914dff4.
- Back-pressure: AES-128 vector with rk_Ready random (about 30% high):
  - Identical key sequence.
  - round_Key_Out and rk_Index stable while stalled.
  - No keys lost or duplicated.
- Control corners:
  - start with key_Size = 3: err pulse, busy stays 0.
  - start while busy is ignored.
  - rst_n asserted mid-RUN: all outputs 0 immediately.
  - A fresh start after reset gives the correct rk0.
